// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and width/index helpers for the matmul_engine block.
package matmul_pkg;

  // Controller states: operand load, result computation, result set complete.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Result address width: enough to index all N*N result entries.
  function automatic int calc_aw(input int n);
    return $clog2(n * n);
  endfunction

  // Result width: full product width plus growth for an N-term sum.
  function automatic int calc_ow(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Row index of a row-major element index.
  function automatic int row_of(input int k, input int n);
    return k / n;
  endfunction

  // Column index of a row-major element index.
  function automatic int col_of(input int k, input int n);
    return k % n;
  endfunction

endpackage

// File: rtl/matmul_dot_unit.sv
// matmul_dot_unit: combinational N-lane dot product of one row of A with one
// column of B. MATMUL_SIGNED_EN selects two's-complement operands; otherwise
// operands are unsigned.
module matmul_dot_unit
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int OW = calc_ow(N, DW)
) (
  input  logic [N-1:0][DW-1:0] a_row,
  input  logic [N-1:0][DW-1:0] b_col,
  output logic [OW-1:0]        dot
);

  logic [OW-1:0] prod_ext [N];

  // One multiplier per lane; operands are widened before the multiply so the
  // full 2*DW-bit product is kept, then extended to the result width.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
`ifdef MATMUL_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    assign prod = $signed({{DW{a_row[gi][DW-1]}}, a_row[gi]}) *
                  $signed({{DW{b_col[gi][DW-1]}}, b_col[gi]});
    assign prod_ext[gi] = {{(OW-2*DW){prod[2*DW-1]}}, prod};
`else
    logic [2*DW-1:0] prod;
    assign prod = {{DW{1'b0}}, a_row[gi]} * {{DW{1'b0}}, b_col[gi]};
    assign prod_ext[gi] = {{(OW-2*DW){1'b0}}, prod};
`endif
  end

  // Sum the lane products; OW bits hold the exact sum in both number formats.
  always_comb begin
    dot = '0;
    for (int l = 0; l < N; l++) begin
      dot = dot + prod_ext[l];
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: N x N matrix multiplier. Operands stream in over a
// valid/ready handshake (A then B, row-major), one result element is computed
// per enabled cycle, and results are read through a registered address port.
// MATMUL_SIGNED_EN selects two's-complement arithmetic (default: unsigned).
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int AW = calc_aw(N),
  parameter int OW = calc_ow(N, DW)
) (
  input  logic          ic,
  input  logic          mr,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [OW-1:0] rd_data
);

  localparam int NN = N * N;
  // Load counter spans 0..2*N*N-1, one bit wider than the element index.
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LD_LAST = LW'(2 * NN - 1);
  localparam logic [LW-1:0] LD_B0   = LW'(NN);
  localparam logic [AW-1:0] K_LAST  = AW'(NN - 1);

  state_t               state_reg;
  logic [LW-1:0]        ld_cnt_reg;
  logic [AW-1:0]        k_reg;
  logic [DW-1:0]        a_mem [NN];
  logic [DW-1:0]        b_mem [NN];
  logic [OW-1:0]        r_mem [NN];

  logic                 accept;
  logic [AW-1:0]        a_idx;
  logic [AW-1:0]        b_idx;
  int                   row_idx;
  int                   col_idx;
  logic [N-1:0][DW-1:0] a_row;
  logic [N-1:0][DW-1:0] b_col;
  logic [OW-1:0]        dot;

  // Operands are accepted in LOAD and DONE; held low while in reset.
  assign in_ready = mr & en & (state_reg != COMPUTE);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_reg == COMPUTE);
  assign done     = (state_reg == DONE);

  assign a_idx   = ld_cnt_reg[AW-1:0];
  assign b_idx   = AW'(ld_cnt_reg - LD_B0);
  assign row_idx = row_of(int'(k_reg), N);
  assign col_idx = col_of(int'(k_reg), N);

  // Gather row i of A and column j of B for the element being computed.
  for (genvar gi = 0; gi < N; gi++) begin : g_gather
    assign a_row[gi] = a_mem[AW'(row_idx * N + gi)];
    assign b_col[gi] = b_mem[AW'(gi * N + col_idx)];
  end

  matmul_dot_unit #(
    .N  (N),
    .DW (DW),
    .OW (OW)
  ) u_dot (
    .a_row (a_row),
    .b_col (b_col),
    .dot   (dot)
  );

  // Controller, operand storage and result bank; everything freezes when en=0.
  always_ff @(posedge ic or negedge mr) begin
    if (!mr) begin
      state_reg  <= LOAD;
      ld_cnt_reg <= '0;
      k_reg      <= '0;
      for (int e = 0; e < NN; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        r_mem[e] <= '0;
      end
    end else if (en) begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (ld_cnt_reg < LD_B0) begin
              a_mem[a_idx] <= in_data;
            end else begin
              b_mem[b_idx] <= in_data;
            end
            if (ld_cnt_reg == LD_LAST) begin
              state_reg  <= COMPUTE;
              ld_cnt_reg <= '0;
              k_reg      <= '0;
            end else begin
              ld_cnt_reg <= ld_cnt_reg + LW'(1);
            end
          end
        end
        COMPUTE: begin
          r_mem[k_reg] <= dot;
          if (k_reg == K_LAST) begin
            state_reg <= DONE;
            k_reg     <= '0;
          end else begin
            k_reg <= k_reg + AW'(1);
          end
        end
        DONE: begin
          // A new job starts with its first operand; previous results stay
          // readable until COMPUTE overwrites them.
          if (accept) begin
            a_mem[0]   <= in_data;
            ld_cnt_reg <= LW'(1);
            state_reg  <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  // Registered result read; runs regardless of en, out-of-range reads give 0.
  always_ff @(posedge ic or negedge mr) begin
    if (!mr) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < NN) begin
      rd_data <= r_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: table-driven and sequence checks of matmul_engine (N=3, DW=4)
// against a plain matrix-multiply reference model.
module tb_matmul_engine;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int NN = 9;
  localparam int AW = 4;
  localparam int OW = 10;

  logic          ic = 1'b0;
  logic          mr;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [OW-1:0] rd_data;

  always #5 ic = ~ic;

  matmul_engine #(.N(N), .DW(DW)) dut (
    .ic       (ic),
    .mr       (mr),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  typedef int mat_t [NN];
  typedef struct {
    int   id;
    mat_t a;
    mat_t b;
    mat_t r;
  } vec_t;

  vec_t vecs [6];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Operand value as the arithmetic sees it.
  function automatic int opv(input int x);
    int u;
    u = x & 15;
`ifdef MATMUL_SIGNED_EN
    return (u >= 8) ? u - 16 : u;
`else
    return u;
`endif
  endfunction

  // Reference: C = A x B with plain integer arithmetic.
  task automatic ref_mm(input mat_t a, input mat_t b, output mat_t r);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int t = 0; t < N; t++) s += opv(a[i*N+t]) * opv(b[t*N+j]);
        r[i*N+j] = s;
      end
    end
  endtask

  // Stream operands p = first..last-1 (A then B); optional random valid gaps
  // and an en=0 window of 3 cycles while operand 5 is pending.
  task automatic load_ops(input mat_t a, input mat_t b, input int first, input int last,
                          input bit stall, input bit en_gap);
    for (int p = first; p < last; p++) begin
      int  v;
      int  tries;
      bit  accepted;
      v = (p < NN) ? a[p] : b[p-NN];
      tries = 0;
      accepted = 1'b0;
      while (!accepted) begin
        @(negedge ic);
        in_data  = DW'(v);
        in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        en       = !(en_gap && p == 5 && tries < 3);
        #1;
        if (!en) check("ready_low_while_en0", {31'd0, in_ready}, 32'd0);
        accepted = in_valid && in_ready;
        @(posedge ic);
        #1;
        tries++;
        if (!accepted && tries > 60) begin
          n_vec++;
          n_fail++;
          $display("FAIL load_timeout: operand %0d not accepted, required acceptance within 60 cycles", p);
          accepted = 1'b1;
        end
      end
    end
    en = 1'b1;
  endtask

  // Run from the final load edge until done; optional en=0 window after 4
  // writes, and optional read-while-write check against the previous results.
  task automatic run_compute(input int stall_len, input bit war, input mat_t old_r,
                             output int edges, output int busy_cnt);
    int writes;
    writes = 0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      @(negedge ic);
      in_valid = 1'b0;
      en = !(edges >= 4 && edges < 4 + stall_len);
      if (war) rd_addr = AW'(writes);
      #1;
      if (busy) busy_cnt++;
      @(posedge ic);
      #1;
      if (war) check("read_during_write_old", {22'd0, rd_data}, {22'd0, OW'(old_r[writes])});
      if (en) writes++;
      edges++;
    end
    en = 1'b1;
  endtask

  // Read every address 0..15; addresses past the bank must read 0.
  task automatic read_all(input mat_t r, input string name);
    for (int ad = 0; ad < 16; ad++) begin
      logic [OW-1:0] exp;
      @(negedge ic);
      rd_addr = AW'(ad);
      @(posedge ic);
      #1;
      exp = (ad < NN) ? OW'(r[ad]) : '0;
      check(name, {22'd0, rd_data}, {22'd0, exp});
    end
  endtask

  initial begin
    mat_t id_a, id_b, id_r, a2, r2, zero_r, tmp;
    int   edges, bc;

    mr = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; rd_addr = '0;

    // Stimulus table.
    for (int i = 0; i < NN; i++) begin
      id_a[i] = (i % 4 == 0) ? 1 : 0;
      id_b[i] = i + 1;
      a2[i]   = (i % 4 == 0) ? 2 : 0;
      zero_r[i] = 0;
    end
    vecs[0].id = 0; vecs[0].a = id_a; vecs[0].b = id_b;
    for (int i = 0; i < NN; i++) begin
`ifdef MATMUL_SIGNED_EN
      vecs[1].a[i] = 8;  vecs[1].b[i] = 8;  vecs[1].r[i] = 192;
      vecs[2].a[i] = 15; vecs[2].b[i] = 7;  vecs[2].r[i] = -21;
`else
      vecs[0].r[i] = i + 1;
      vecs[1].a[i] = 15; vecs[1].b[i] = 15; vecs[1].r[i] = 675;
      vecs[2].a[i] = 15; vecs[2].b[i] = 7;  vecs[2].r[i] = 315;
`endif
    end
`ifdef MATMUL_SIGNED_EN
    ref_mm(id_a, id_b, tmp);
    vecs[0].r = tmp;
`endif
    vecs[1].id = 1; vecs[2].id = 2;
    for (int v = 3; v < 6; v++) begin
      vecs[v].id = v;
      for (int i = 0; i < NN; i++) begin
        vecs[v].a[i] = int'($urandom_range(0, 15));
        vecs[v].b[i] = int'($urandom_range(0, 15));
      end
      ref_mm(vecs[v].a, vecs[v].b, tmp);
      vecs[v].r = tmp;
    end
    ref_mm(id_a, id_b, id_r);
    ref_mm(a2, id_b, r2);

    // Reset state.
    repeat (3) @(posedge ic);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_data", {22'd0, rd_data}, 32'd0);
    @(negedge ic);
    mr = 1'b1;
    #1;
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Table-driven jobs, back to back.
    for (int v = 0; v < 6; v++) begin
      load_ops(vecs[v].a, vecs[v].b, 0, 2 * NN, 1'b0, 1'b0);
      run_compute(0, 1'b0, zero_r, edges, bc);
      check("done_latency", edges, 32'd9);
      check("busy_cycles", bc, 32'd9);
      read_all(vecs[v].r, "table_result");
    end

    // Stalled load (valid gaps, en=0 during load) and en=0 for 3 cycles at k=4.
    load_ops(id_a, id_b, 0, 2 * NN, 1'b1, 1'b1);
    run_compute(3, 1'b0, zero_r, edges, bc);
    check("stall_done_latency", edges, 32'd12);
    check("stall_busy_cycles", bc, 32'd12);
    read_all(id_r, "stall_result");

    // Re-arm from DONE: first handshake drops done, old results still readable.
    load_ops(a2, id_b, 0, 1, 1'b0, 1'b0);
    check("rearm_done_drops", {31'd0, done}, 32'd0);
    check("rearm_in_load", {31'd0, busy}, 32'd0);
    @(negedge ic);
    in_valid = 1'b0;
    rd_addr = AW'(8);
    @(posedge ic);
    #1;
    check("rearm_old_r8", {22'd0, rd_data}, {22'd0, OW'(id_r[8])});
    load_ops(a2, id_b, 1, 2 * NN, 1'b0, 1'b0);
    run_compute(0, 1'b1, id_r, edges, bc);
    check("rearm_done_latency", edges, 32'd9);
    read_all(r2, "rearm_result");

    // Reset at k=5 discards everything; a fresh job then computes correctly.
    load_ops(vecs[4].a, vecs[4].b, 0, 2 * NN, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge ic);
      in_valid = 1'b0;
      @(posedge ic);
    end
    @(negedge ic);
    mr = 1'b0;
    #1;
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rd_data", {22'd0, rd_data}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge ic);
    mr = 1'b1;
    read_all(zero_r, "midreset_cleared");
    load_ops(vecs[3].a, vecs[3].b, 0, 2 * NN, 1'b0, 1'b0);
    run_compute(0, 1'b0, zero_r, edges, bc);
    check("post_reset_latency", edges, 32'd9);
    read_all(vecs[3].r, "post_reset_result");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N matrix multiplier and successor to the fixed 3×3, 4-bit multiplier. Operands stream in serially over a valid/ready handshake. An N-lane dot-product unit then computes one result element per cycle into an internal result bank. Results can be read at random through a registered address port, and the block re-arms for a new operand set without a reset.

## Interface
- N, 3, matrix dimension (≥2)
- DW, 4, operand width in bits
- AW, $clog2(N*N), result address width (derived)
- OW, 2*DW+$clog2(N), result width (derived; N=3, DW=4 → 10)
- ic  in  1  clock; all state updates on the rising edge
- mr  in  1  reset; asynchronous, active-low
- en  in  1  global enable; when 0, all state, counters and the result bank freeze
- in_valid  in  1  operand present
- in_ready  out  1  operand accepted when in_valid & in_ready at a rising edge
- in_data  in  DW  operand value
- busy  out  1  high while in COMPUTE
- done  out  1  high while in DONE (result set complete)
- rd_addr  in  AW  result index, row-major: i*N+j
- rd_data  out  OW  registered result read

## Operation
- FSM states:
  - LOAD is the reset state.
  - COMPUTE
  - DONE
- LOAD:
  - in_ready = en.
  - Each handshake stores in_data at ld_cnt.
  - ld_cnt 0..N²-1 fills A row-major; N²..2N²-1 fills B row-major.
  - The handshake at ld_cnt = 2N²-1 moves to COMPUTE with k=0 and clears ld_cnt.
- COMPUTE:
  - in_ready = 0.
  - Each enabled cycle writes R[k] = Σ_t A[i][t]·B[t][j], where i=k/N and j=k%N.
  - k increments.
  - The write of k = N²-1 moves to DONE.
- DONE:
  - in_ready = en.
  - An accepted handshake stores to A[0] (ld_cnt→1) and returns to LOAD.
  - R is retained until overwritten by the next COMPUTE.
- Arithmetic is unsigned by default:
  - Each product is 2·DW bits, zero-extended to OW.
  - The sum is exact; overflow is impossible at OW.
- Reads:
  - rd_data is registered on the rising edge from R[rd_addr].
  - rd_addr ≥ N² returns 0.
  - Reads are legal in every state; during COMPUTE, unwritten entries return their previous contents.
- en = 0 in any state:
  - in_ready is 0, so no handshake occurs.
  - The state, k and ld_cnt hold; R is not written.
  - rd_data still updates.

## Timing
- Reset (mr low, asynchronous): state=LOAD, ld_cnt=0, k=0, all A/B/R = 0, in_ready=0 (goes to en after release), busy=0, done=0, rd_data=0.
- Reset mid-load or mid-compute discards all operands and results.
- Operand throughput: one per cycle.
- Compute latency: done rises exactly N² enabled edges after the final load handshake edge (9 for N=3).
- busy is high for exactly those N² enabled cycles (longer if en drops).
- Read latency: 1 cycle from rd_addr to rd_data.
- Back-to-back jobs: a handshake in DONE drops done on the same edge that stores A[0].
- Simultaneous read of R[k] while R[k] is written returns the old value (write-after-read).

## Configuration
- MATMUL_SIGNED_EN:
  - Defined: operands are two's-complement. Products are signed 2·DW and sign-extended to OW; rd_data is two's-complement OW.
  - Undefined: unsigned operation as above.
  - OW is unchanged in both cases; exact for all inputs including (-2^(DW-1))².

## Structure
- Package matmul_pkg:
  - state enum {LOAD, COMPUTE, DONE}
  - OW/AW width functions
  - row/column index helpers
- Sub-module matmul_dot_unit:
  - N multipliers plus an adder tree; purely combinational.
  - Inputs are row i of A and column j of B; output is OW bits.
- Top level holds the FSM, counters, operand storage, result bank and read register.

## Test plan
- **Identity:** N=3, DW=4, A=I, B=1..9 row-major → rd_data at addr 0..8 = 1..9; done 9 edges after the last load; busy high 9 cycles.
- **Max unsigned:** all A,B = 15 → every R = 675 (10'h2A3); addr 9..15 → 0.
- **Stalls:**
  - in_valid toggled 50% during load, plus en=0 for 3 cycles at k=4 → done delayed by exactly 3 cycles.
  - R values identical to the unstalled run.
  - in_ready=0 while en=0.
- **Reset mid-compute:** mr low at k=5 → done=0, busy=0, rd_data=0 at all addresses; a subsequent full load computes correctly.
- **Re-arm:**
  - In DONE, load a new set with A=2·I and the same B → first handshake drops done.
  - Old R remains readable until rewritten; final R = 2,4,..,18.
- **Signed (MATMUL_SIGNED_EN):**
  - A all -8, B all -8 → R = 192.
  - A all -1, B all 7 → R = -21 (10'h3EB).
